// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform.
//
// Reports the high time (duty) and total length (period) of the last complete PWM period, in
// clock cycles. A period is counted from one rising edge of the sampled input up to, but not
// including, the next one. Each new measurement is published with a one-cycle valid strobe.
// timeout is a level flag. It rises when no rising edge arrives within 2^bit_width - 1 cycles,
// and it clears on the next valid measurement.
//
// Optional feature macro: PWM_CAPTURE_SYNC_EN.
//   Defined:   two synchronizer flops sit ahead of the sampling flop, for an asynchronous
//              pwm_in. Latency grows from 2 to 4 clocks; measured values are unchanged.
//   Undefined: pwm_in must be synchronous to clk.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   pwm_in  in   PWM waveform to measure
//   duty    out  high cycles in the last complete period
//   period  out  total cycles in the last complete period
//   valid   out  one-cycle pulse when duty/period update
//   timeout out  no rising edge within 2^bit_width - 1 cycles

module pwm_capture #(
  parameter int unsigned bit_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  output logic [bit_width-1:0] duty,
  output logic [bit_width-1:0] period,
  output logic                 valid,
  output logic                 timeout
);

  typedef logic [bit_width-1:0] cnt_t;

  typedef enum logic {
    StIdle,
    StMeasure
  } state_e;

  logic s_in;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

  assign s_in = sync_q[1];
`else
  assign s_in = pwm_in;
`endif

  // s_q is the sampled input; s_d_q is the same value one cycle older, used for edge detection.
  logic s_q, s_d_q;
  logic rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= 1'b0;
      s_d_q <= 1'b0;
    end else begin
      s_q   <= s_in;
      s_d_q <= s_q;
    end
  end

  assign rise = s_q & ~s_d_q;

  state_e state_q, state_d;
  cnt_t   cnt_period_q, cnt_period_d;
  cnt_t   cnt_high_q, cnt_high_d;
  cnt_t   duty_q, duty_d;
  cnt_t   period_q, period_d;
  logic   valid_q, valid_d;
  logic   timeout_q, timeout_d;
  logic   cnt_max;

  assign cnt_max = (cnt_period_q == '1);

  always_comb begin
    state_d      = state_q;
    cnt_period_d = cnt_period_q;
    cnt_high_d   = cnt_high_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          // The first edge is only a reference. It starts a measurement and publishes nothing.
          state_d      = StMeasure;
          cnt_period_d = cnt_t'(1);
          cnt_high_d   = cnt_t'(1);
        end else if (cnt_max) begin
          timeout_d    = 1'b1;
          cnt_period_d = '0;
        end else begin
          cnt_period_d = cnt_period_q + cnt_t'(1);
        end
      end
      StMeasure: begin
        // An edge on the all-ones count still publishes, because rise takes priority.
        if (rise) begin
          period_d     = cnt_period_q;
          duty_d       = cnt_high_q;
          valid_d      = 1'b1;
          timeout_d    = 1'b0;
          cnt_period_d = cnt_t'(1);
          cnt_high_d   = cnt_t'(1);
        end else if (cnt_max) begin
          timeout_d    = 1'b1;
          state_d      = StIdle;
          cnt_period_d = '0;
        end else begin
          cnt_period_d = cnt_period_q + cnt_t'(1);
          cnt_high_d   = cnt_high_q + cnt_t'(s_q);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_period_q <= '0;
      cnt_high_q   <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_period_q <= cnt_period_d;
      cnt_high_q   <= cnt_high_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign duty    = duty_q;
  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture (bit_width 4).
// The reference model works from the list of rising edges of the sampled input stream. A
// measurement is expected at a rise whose predecessor (since reset) lies at most 15 cycles back.
// Duty is the count of high samples in that window. timeout sets when 15 cycles pass after a rise
// with no further rise, or 16 cycles after reset with no rise at all.

module tb_pwm_capture;

  localparam int unsigned BW  = 4;
  localparam int          MAX = (1 << BW) - 1;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int          DLY = 3;
`else
  localparam int          DLY = 1;
`endif

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          pwm_in = 1'b0;
  logic [BW-1:0] duty;
  logic [BW-1:0] period;
  logic          valid;
  logic          timeout;

  always #5 clk = ~clk;

  pwm_capture #(
    .bit_width(BW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .timeout(timeout)
  );

  int            vectors = 0;
  int            errors  = 0;
  int            t       = 0;  // posedges since reset release
  int            last_rise = 0;  // 0 = no rise since reset
  bit            v_hist [0:16383];  // pwm_in value sampled at each posedge
  logic          exp_valid   = 1'b0;
  logic          exp_timeout = 1'b0;
  logic [BW-1:0] exp_duty    = '0;
  logic [BW-1:0] exp_period  = '0;

  function automatic bit s_at(input int j);
    return (j >= 1) ? v_hist[j] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid", BW'(valid), BW'(exp_valid));
    check("timeout", BW'(timeout), BW'(exp_timeout));
    check("duty", duty, exp_duty);
    check("period", period, exp_period);
  endtask

  // Expected outputs after posedge t, derived from rise positions in the sample history.
  task automatic model_step();
    bit rise;
    int sum;
    rise      = s_at(t - DLY) && !s_at(t - DLY - 1);
    exp_valid = 1'b0;
    if (rise) begin
      if (last_rise >= 1 && (t - last_rise) <= MAX) begin
        sum = 0;
        for (int j = last_rise; j < t; j++) sum += int'(s_at(j - DLY));
        exp_valid   = 1'b1;
        exp_period  = BW'(t - last_rise);
        exp_duty    = BW'(sum);
        exp_timeout = 1'b0;
      end
      last_rise = t;
    end else if ((last_rise >= 1) ? (t - last_rise == MAX) : (t == MAX + 1)) begin
      exp_timeout = 1'b1;
    end
  endtask

  // Called at a negedge: value is sampled at the next posedge, outputs checked at the negedge after.
  task automatic drive(input logic val);
    pwm_in = val;
    @(posedge clk);
    t++;
    v_hist[t] = val;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic pwm_period(input int h, input int l);
    repeat (h) drive(1'b1);
    repeat (l) drive(1'b0);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear without a clock.
  task automatic reset_dut();
    #2;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    exp_valid   = 1'b0;
    exp_timeout = 1'b0;
    exp_duty    = '0;
    exp_period  = '0;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    t         = 0;
    last_rise = 0;
  endtask

  initial begin
    int h;
    int l;
    @(negedge clk);
    reset_dut();

    // Constant low from reset: timeout after 16 cycles, no valid.
    repeat (20) drive(1'b0);

    // Loopback-style duty 3 / period 8.
    repeat (6) pwm_period(3, 5);

    // Duty sweep at period 8.
    for (int d = 1; d <= 7; d++) begin
      pwm_period(d, 8 - d);
      pwm_period(d, 8 - d);
    end

    // Constant low, then restore duty 3.
    repeat (20) drive(1'b0);
    repeat (3) pwm_period(3, 5);

    // Constant high, then restore.
    repeat (20) drive(1'b1);
    repeat (3) pwm_period(3, 5);

    // Period 15 is measured; period 16 times out.
    repeat (3) pwm_period(4, 11);
    repeat (3) pwm_period(4, 12);
    repeat (3) pwm_period(4, 11);

    // Minimum period.
    repeat (4) pwm_period(1, 1);

    // Reset in the middle of a high phase.
    repeat (2) pwm_period(3, 5);
    drive(1'b1);
    drive(1'b1);
    reset_dut();
    repeat (4) pwm_period(3, 5);

    // Random periods, occasionally too long.
    for (int i = 0; i < 40; i++) begin
      h = int'($urandom_range(1, 9));
      l = int'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) h += 10;
      pwm_period(h, l);
    end
    repeat (20) drive(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
